macro_op_arbiter: RTL and testbench

MACRO_OP_ARBITER -- requirements
Module: macro_op_arbiter

---
 rtl/macro_op_arbiter.sv | 141 ++++++++++++++
 tb/tb_macro_op_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/macro_op_arbiter.sv
// macro_op_arbiter: round-robin arbiter that serialises macro operations
// (ZERO / LOAD / INCR / CMP) from NREQ requesters onto one shared register.
// A transaction walks IDLE -> GRANT -> EXEC -> RESP, so an ack always comes
// three cycles after the request is seen, and acks are at least four cycles apart.
// Optional feature: define MACRO_ARB_SATURATE_EN so that INCR saturates at
// all-ones instead of wrapping around to zero.
module macro_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      dout,
  output logic                  cmp_eq
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_ZERO = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_INCR = 2'd2;
  localparam logic [1:0] OP_CMP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  win_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] reg_q;
  logic             cmp_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  ack_q;

  logic [IDXW-1:0]  win_d;
  logic             found_d;
  logic [IDXW-1:0]  cand;
  logic [WIDTH-1:0] reg_d;
  logic             cmp_d;

  // Round-robin search starting at ptr_q and wrapping; the first active request wins.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NREQ);
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  // Result of the latched operation; only committed to the register while in EXEC.
  always_comb begin
    reg_d = reg_q;
    cmp_d = cmp_q;
    case (op_q)
      OP_ZERO: reg_d = '0;
      OP_LOAD: reg_d = opnd_q;
      OP_INCR: begin
`ifdef MACRO_ARB_SATURATE_EN
        reg_d = (reg_q == {WIDTH{1'b1}}) ? reg_q : reg_q + WIDTH'(1);
`else
        reg_d = reg_q + WIDTH'(1);
`endif
      end
      OP_CMP:  cmp_d = (reg_q == opnd_q);
      default: reg_d = reg_q;
    endcase
  end

  // Transaction FSM; grant, ack, register and compare flag are all registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_ZERO;
      opnd_q  <= '0;
      reg_q   <= '0;
      cmp_q   <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          gnt_q <= '0;
          if (found_d) begin
            state_q <= GRANT;
            win_q   <= win_d;
            op_q    <= op[2*win_d +: 2];
            opnd_q  <= din[WIDTH*win_d +: WIDTH];
            gnt_q   <= NREQ'(1) << win_d;
          end
        end
        GRANT: begin
          state_q <= EXEC;
        end
        EXEC: begin
          reg_q   <= reg_d;
          cmp_q   <= cmp_d;
          ack_q   <= NREQ'(1) << win_q;
          state_q <= RESP;
        end
        RESP: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + IDXW'(1);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign busy   = (state_q != IDLE);
  assign dout   = reg_q;
  assign cmp_eq = cmp_q;

endmodule

// File: tb/tb_macro_op_arbiter.sv
// tb_macro_op_arbiter: self-checking bench for macro_op_arbiter with the
// default NREQ=4, WIDTH=8. Expected ack results are queued when a request
// is driven and compared by a monitor when the matching ack pulse appears.
// Honours MACRO_ARB_SATURATE_EN for the INCR-at-0xFF expectation.
module tb_macro_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  localparam logic [1:0] OP_ZERO = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_INCR = 2'd2;
  localparam logic [1:0] OP_CMP  = 2'd3;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [7:0] din;
    logic [7:0] expDout;
    logic       expCmp;
  } vecT;

  typedef struct {
    int         idx;
    logic [7:0] dout;
    logic       cmp;
  } expT;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [WIDTH-1:0]      dout;
  logic                  cmp_eq;

  int  checks = 0;
  int  errors = 0;
  expT sbQ[$];
  vecT vecs[10];

  macro_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .din    (din),
    .gnt    (gnt),
    .ack    (ack),
    .busy   (busy),
    .dout   (dout),
    .cmp_eq (cmp_eq)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls beyond every local bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] o, input logic [7:0] d);
    req[idx]          = 1'b1;
    op[2*idx +: 2]    = o;
    din[WIDTH*idx +: WIDTH] = d;
  endtask

  task automatic pushExp(input int idx, input logic [7:0] d, input logic c);
    expT e;
    e.idx  = idx;
    e.dout = d;
    e.cmp  = c;
    sbQ.push_back(e);
  endtask

  // Hold reset for two cycles, check every reset value, then release on a falling edge.
  task automatic resetDut();
    rst = 1'b0;
    req = '0;
    op  = '0;
    din = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDout", dout, 0);
    checkOutput("resetGnt", gnt, 0);
    checkOutput("resetAck", ack, 0);
    checkOutput("resetCmpEq", cmp_eq, 0);
    rst = 1'b1;
  endtask

  // Count falling edges until an ack shows up; 99 means it never came.
  task automatic waitAck(output int cycles);
    cycles = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        cycles = c;
        return;
      end
    end
  endtask

  // One isolated request: queue the expectation, drive it, and check the ack latency.
  task automatic runOp(input int idx, input logic [1:0] o, input logic [7:0] d,
                       input logic [7:0] expDout, input logic expCmp);
    int c;
    pushExp(idx, expDout, expCmp);
    applyStimulus(idx, o, d);
    waitAck(c);
    checkOutput("ackLatency", c, 3);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  // Serve several pending requests, dropping each one as it is acknowledged.
  task automatic serviceAll(input int expectN);
    int lastT;
    int n;
    lastT = 0;
    n     = 0;
    for (int t = 1; t <= 60 && n < expectN; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        if (n == 0) checkOutput("firstLatency", t, 3);
        else        checkOutput("ackSpacing", t - lastT, 4);
        lastT = t;
        n++;
        req = req & ~ack;
      end
    end
    checkOutput("ackCount", n, expectN);
    @(negedge clk);
  endtask

  // Scoreboard monitor plus one-hot and idle-grant invariants, sampled on falling edges.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      checkOutput("gntOneHot0", 32'($onehot0(gnt)), 1);
      checkOutput("ackOneHot0", 32'($onehot0(ack)), 1);
      if (!busy) checkOutput("gntIdleZero", gnt, 0);
      if (ack != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedAck", ack, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("ackIdx", ack, 32'(1) << e.idx);
          checkOutput("ackDout", dout, e.dout);
          checkOutput("ackCmpEq", cmp_eq, e.cmp);
        end
      end
    end
  end

  initial begin
    logic [7:0] incrFF;
    int c;
`ifdef MACRO_ARB_SATURATE_EN
    incrFF = 8'hFF;
`else
    incrFF = 8'h00;
`endif
    vecs[0] = '{0, OP_LOAD, 8'h5A, 8'h5A, 1'b0};
    vecs[1] = '{1, OP_LOAD, 8'h33, 8'h33, 1'b0};
    vecs[2] = '{2, OP_CMP,  8'h33, 8'h33, 1'b1};
    vecs[3] = '{3, OP_CMP,  8'h34, 8'h33, 1'b0};
    vecs[4] = '{0, OP_INCR, 8'h00, 8'h34, 1'b0};
    vecs[5] = '{1, OP_ZERO, 8'hAA, 8'h00, 1'b0};
    vecs[6] = '{2, OP_LOAD, 8'hFF, 8'hFF, 1'b0};
    vecs[7] = '{3, OP_INCR, 8'h00, incrFF, 1'b0};
    vecs[8] = '{0, OP_CMP,  incrFF, incrFF, 1'b1};
    vecs[9] = '{1, OP_LOAD, 8'hC3, 8'hC3, 1'b1};

    // All four requesters INCR from zero: served 0,1,2,3 four cycles apart.
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      pushExp(i, 8'(i + 1), 1'b0);
      applyStimulus(i, OP_INCR, 8'h00);
    end
    serviceAll(4);
    checkOutput("burstFinalDout", dout, 8'h04);

    // LOAD 0x5A from requester 0 moves the pointer to 1, so 1 beats 0 next.
    resetDut();
    runOp(0, OP_LOAD, 8'h5A, 8'h5A, 1'b0);
    pushExp(1, 8'h22, 1'b0);
    pushExp(0, 8'h11, 1'b0);
    applyStimulus(0, OP_LOAD, 8'h11);
    applyStimulus(1, OP_LOAD, 8'h22);
    serviceAll(2);

    // Table of isolated single-requester operations from a clean reset.
    resetDut();
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].idx, vecs[i].op, vecs[i].din, vecs[i].expDout, vecs[i].expCmp);
    end
    checkOutput("tableFinalDout", dout, 8'hC3);

    // Reset during EXEC of LOAD 0x77 aborts it; lowest requester wins afterwards.
    applyStimulus(2, OP_LOAD, 8'h77);
    @(negedge clk);
    checkOutput("grantPhaseGnt", gnt, 4'b0100);
    checkOutput("grantPhaseBusy", busy, 1);
    @(negedge clk);
    checkOutput("execPhaseGnt", gnt, 4'b0100);
    rst = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDout", dout, 0);
    checkOutput("abortGnt", gnt, 0);
    checkOutput("abortAck", ack, 0);
    checkOutput("abortCmpEq", cmp_eq, 0);
    applyStimulus(1, OP_LOAD, 8'h44);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abortNoAck", ack, 0);
    end
    rst = 1'b1;
    pushExp(1, 8'h44, 1'b0);
    pushExp(2, 8'h77, 1'b0);
    serviceAll(2);

    // Operand and opcode changes after the grant must not matter.
    pushExp(0, 8'h10, 1'b0);
    applyStimulus(0, OP_LOAD, 8'h10);
    @(negedge clk);
    op[1:0]  = OP_ZERO;
    din[7:0] = 8'h20;
    @(negedge clk);
    din[7:0] = 8'h30;
    waitAck(c);
    checkOutput("lateChangeLatency", c, 1);
    req[0] = 1'b0;
    @(negedge clk);

    // Dropping the request after the grant still completes the INCR.
    pushExp(3, 8'h11, 1'b0);
    applyStimulus(3, OP_INCR, 8'h00);
    @(negedge clk);
    req[3] = 1'b0;
    waitAck(c);
    checkOutput("droppedReqLatency", c, 2);
    repeat (3) @(negedge clk);
    checkOutput("finalDout", dout, 8'h11);
    checkOutput("scoreboardEmpty", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
